// File: rtl/symbol_pkg.sv
// Shared definitions for the symbol packer.
//   SYM_W_DEF / NSYM_DEF : default symbol width and symbols per output word
//   count_width()        : width of a counter that must hold 0..nsym
//   state_t              : FILL (collecting symbols) / HOLD (word presented)
package symbol_pkg;

    localparam int unsigned SYM_W_DEF = 2;
    localparam int unsigned NSYM_DEF  = 4;

    function automatic int unsigned count_width(input int unsigned nsym);
        return $clog2(nsym + 1);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/symbol_packer.sv
// Packs SYM_W-bit symbols from a first-word-fall-through FIFO into words of
// NSYM symbols (symbol k at bits [k*SYM_W +: SYM_W]). A flush emits a
// partially filled word; unfilled slots read 0.
// Ports:
//   clk, reset (async, active-low)
//   fifo_dout, fifo_empty : upstream FIFO head / empty flag
//   fifo_pop              : consume fifo_dout at the next rising edge
//   flush                 : emit the partial word (ignored while holding)
//   word_data, word_count : packed word and number of valid symbols
//   word_valid/word_ready : downstream handshake, word held until accepted
module symbol_packer
    import symbol_pkg::*;
#(
    parameter int unsigned SYM_W = SYM_W_DEF,
    parameter int unsigned NSYM  = NSYM_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SYM_W-1:0]              fifo_dout,
    input  logic                          fifo_empty,
    output logic                          fifo_pop,
    input  logic                          flush,
    output logic [SYM_W*NSYM-1:0]         word_data,
    output logic [count_width(NSYM)-1:0]  word_count,
    output logic                          word_valid,
    input  logic                          word_ready
);

    localparam int unsigned     CW   = count_width(NSYM);
    localparam logic [CW-1:0]   FULL = CW'(NSYM);

    state_t                  state, state_n;
    logic [CW-1:0]           idx, idx_n;
    logic [SYM_W*NSYM-1:0]   data_n;

    // idx doubles as the symbol count of the word being built or held
    assign word_count = idx;
    assign word_valid = (state == HOLD);

    always_comb begin
        // reset gates the pop so no symbol is consumed while in reset
        fifo_pop = reset && !fifo_empty && ((state == FILL) || word_ready);
        state_n  = state;
        idx_n    = idx;
        data_n   = word_data;

        case (state)
            FILL: begin
                if (fifo_pop) begin
                    for (int unsigned k = 0; k < NSYM; k++) begin
                        if (idx == CW'(k)) begin
                            data_n[k*SYM_W +: SYM_W] = fifo_dout;
                        end
                    end
                    idx_n = idx + CW'(1);
                    if ((idx_n == FULL) || flush) begin
                        state_n = HOLD;
                    end
                end else if (flush && (idx != '0)) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    data_n  = '0;
                    idx_n   = '0;
                    state_n = FILL;
                    // a pop during handoff starts the next word in slot 0
                    if (fifo_pop) begin
                        data_n[SYM_W-1:0] = fifo_dout;
                        idx_n             = CW'(1);
                        if (NSYM == 1) begin
                            state_n = HOLD;
                        end
                    end
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            idx       <= '0;
            word_data <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            word_data <= data_n;
        end
    end

endmodule

// File: tb/tb_symbol_packer.sv
// Self-checking bench for symbol_packer with a 2-entry first-word-fall-through
// FIFO upstream. Expected words go into a queue when stimulus is issued and
// are compared when the packer hands a word off.
module tb_symbol_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [1:0] push_sym;
    logic [1:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_pop;
    logic       flush;
    logic [7:0] word_data;
    logic [2:0] word_count;
    logic       word_valid;
    logic       word_ready;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] count;
    } word_t;

    word_t exp_q[$];

    typedef struct {
        logic [7:0]  syms;
        int unsigned n;
        bit          do_flush;
        logic [7:0]  exp_data;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    // 2-entry FWFT FIFO
    logic [1:0] mem [2];
    logic       wp, rp;
    logic [1:0] fcnt;
    logic       do_push;

    assign do_push    = push && (fcnt != 2'd2);
    assign fifo_dout  = mem[rp];
    assign fifo_empty = (fcnt == 2'd0);
    assign fifo_full  = (fcnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            fcnt <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= push_sym;
                wp      <= ~wp;
            end
            if (fifo_pop) begin
                rp <= ~rp;
            end
            if (do_push && !fifo_pop) begin
                fcnt <= fcnt + 2'd1;
            end else if (!do_push && fifo_pop) begin
                fcnt <= fcnt - 2'd1;
            end
        end
    end

    symbol_packer #(
        .SYM_W (2),
        .NSYM  (4)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .word_data  (word_data),
        .word_count (word_count),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // handoff monitor and pop counter
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_pop) pops++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, word_data}, 32'hFFFF_FFFF);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("word_data", {24'd0, word_data}, {24'd0, e.data});
                    check("word_count", {29'd0, word_count}, {29'd0, e.count});
                end
                if (!fifo_empty) begin
                    check("zero_bubble_pop", {31'd0, fifo_pop}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] s);
        int n = 0;
        while (fifo_full && n < 200) begin
            tick();
            n++;
        end
        if (fifo_full) begin
            check("push_timeout", 32'd1, 32'd0);
        end else begin
            push     = 1'b1;
            push_sym = s;
            tick();
            push     = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!fifo_empty && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, fifo_empty}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [2:0] c);
        word_t w;
        w.data  = d;
        w.count = c;
        exp_q.push_back(w);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_count"}, {29'd0, word_count}, 32'd0);
        check({tag, "_data"},  {24'd0, word_data}, 32'd0);
        check({tag, "_pop"},   {31'd0, fifo_pop}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] syms;
        logic [7:0] acc;
        logic [1:0] s;

        vecs[0] = '{8'h39, 4, 1'b0, 8'h39, 3'd4};
        vecs[1] = '{8'h07, 2, 1'b1, 8'h07, 3'd2};
        vecs[2] = '{8'hAA, 4, 1'b0, 8'hAA, 3'd4};
        vecs[3] = '{8'hE4, 4, 1'b0, 8'hE4, 3'd4};
        vecs[4] = '{8'h03, 1, 1'b1, 8'h03, 3'd1};
        vecs[5] = '{8'h31, 3, 1'b1, 8'h31, 3'd3};
        vecs[6] = '{8'h1B, 4, 1'b0, 8'h1B, 3'd4};

        rst_n      = 1'b0;
        push       = 1'b0;
        push_sym   = 2'd0;
        flush      = 1'b0;
        word_ready = 1'b1;
        tick();
        tick();
        reset_checks("reset_init");
        rst_n = 1'b1;
        tick();

        // table-driven words
        for (int i = 0; i < 7; i++) begin
            pops = 0;
            expect_word(vecs[i].exp_data, vecs[i].exp_count);
            syms = vecs[i].syms;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                push_one(syms[k*2 +: 2]);
            end
            if (vecs[i].do_flush) begin
                wait_empty("flush_wait_empty");
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            drain("vec_drain");
            check("vec_pops", pops, vecs[i].n);
        end

        // backpressure: first word held, FIFO fills, pops stop
        pops       = 0;
        word_ready = 1'b0;
        expect_word(8'h39, 3'd4);
        expect_word(8'h1B, 3'd4);
        fork
            begin
                push_one(2'd1); push_one(2'd2); push_one(2'd3); push_one(2'd0);
                push_one(2'd3); push_one(2'd2); push_one(2'd1); push_one(2'd0);
            end
            begin
                int n = 0;
                while (!(word_valid && fifo_full) && n < 100) begin
                    tick();
                    n++;
                end
                check("bp_full", {31'd0, fifo_full}, 32'd1);
                for (int c = 0; c < 5; c++) begin
                    check("bp_hold_data",  {24'd0, word_data}, 32'h39);
                    check("bp_hold_count", {29'd0, word_count}, 32'd4);
                    check("bp_hold_valid", {31'd0, word_valid}, 32'd1);
                    check("bp_no_pop",     {31'd0, fifo_pop}, 32'd0);
                    tick();
                end
                word_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_pops", pops, 32'd8);

        // flush with nothing collected is ignored
        check("idle_count", {29'd0, word_count}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("idle_flush_valid", {31'd0, word_valid}, 32'd0);
            check("idle_flush_pop",   {31'd0, fifo_pop}, 32'd0);
            tick();
        end

        // continuous stream of 12 symbols
        pops = 0;
        for (int w = 0; w < 3; w++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
                s   = 2'($urandom_range(0, 3));
                acc = acc | (8'(s) << (k * 2));
                push_one(s);
            end
            expect_word(acc, 3'd4);
        end
        drain("stream_drain");
        check("stream_pops", pops, 32'd12);

        // reset mid-fill discards the partial word
        push_one(2'd1);
        push_one(2'd3);
        wait_empty("rst_wait_empty");
        tick();
        rst_n = 1'b0;
        #1;
        reset_checks("reset_mid");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pops = 0;
        expect_word(8'hAA, 3'd4);
        push_one(2'd2); push_one(2'd2); push_one(2'd2); push_one(2'd2);
        drain("rst_drain");
        check("rst_pops", pops, 32'd4);
        tick();
        tick();
        check("rst_no_extra", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/symbol_packer.md
SYMBOL_PACKER -- requirements
Module: symbol_packer

Interface
REQ-001 SHALL have parameter SYM_W, default 2: width of one symbol from the upstream FIFO.
REQ-002 SHALL have parameter NSYM, default 4: symbols per output word.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fifo_dout  in  SYM_W  head entry of the upstream first-word-fall-through FIFO.
REQ-006 fifo_empty  in  1  upstream FIFO holds no entries.
REQ-007 fifo_pop  out  1  consumes fifo_dout at the next rising edge.
REQ-008 flush  in  1  request to emit a partially filled word.
REQ-009 word_data  out  SYM_W*NSYM  packed word; symbol k occupies bits [k*SYM_W +: SYM_W].
REQ-010 word_count  out  clog2(NSYM+1)  number of valid symbols in word_data (1..NSYM while word_valid).
REQ-011 word_valid  out  1  word_data/word_count valid; held until accepted.
REQ-012 word_ready  in  1  downstream accepts the word when high together with word_valid.

Function
REQ-013 SHALL implement two states: FILL (collecting symbols) and HOLD (word presented).
REQ-014 fifo_pop SHALL be combinational: 1 iff reset is high, fifo_empty = 0, and either (FILL) or (HOLD and word_ready = 1).
REQ-015 On each pop, the symbol SHALL be written into slot idx, and idx SHALL increment. Slot 0 receives the first symbol popped after an empty word.
REQ-016 When the NSYM-th symbol is popped in FILL, the FSM SHALL move to HOLD. word_valid = 1 and word_count = NSYM SHALL appear in the cycle after that edge (1-cycle latency).
REQ-017 In FILL, flush = 1 with idx > 0 or with a pop in the same cycle SHALL move the FSM to HOLD, including any symbol popped that cycle. word_count SHALL equal the symbols held.
REQ-018 In FILL, flush = 1 with idx = 0 and no pop SHALL be ignored.
REQ-019 Unfilled slots of a partial word SHALL read 0.
REQ-020 word_data, word_count and word_valid SHALL be registered and SHALL remain stable in HOLD while word_ready = 0. No pops SHALL occur in that period.
REQ-021 Handoff in HOLD with word_ready = 1 and no pop: next state FILL, idx = 0, all slots cleared, word_valid = 0.
REQ-022 Handoff in HOLD with word_ready = 1 and a simultaneous pop: next state FILL, new symbol in slot 0, idx = 1, other slots 0. This gives zero-bubble throughput.
REQ-023 flush SHALL be ignored in HOLD.
REQ-024 When NSYM = 1, every pop SHALL produce a full word, and the FSM SHALL move to HOLD each time.

Reset
REQ-025 While reset = 0, all of the following SHALL hold asynchronously: state = FILL, idx = 0, word_data = 0, word_count = 0, word_valid = 0, fifo_pop = 0.
REQ-026 Reset asserted mid-fill or in HOLD SHALL discard the partial or held word with no further output.
REQ-027 The first pop after reset release SHALL occur no earlier than the first rising edge after release.

Structure
REQ-028 Package symbol_pkg SHALL hold SYM_W and NSYM defaults, the count-width function, and the FILL/HOLD state enum.
REQ-029 symbol_packer SHALL be a single module with no sub-modules.
REQ-030 The bench SHALL instantiate the existing 2-entry FiFo upstream, with fifo_pop driving its pop input.

Verification
REQ-031 Push 1,2,3,0 with word_ready = 1 -> exactly 4 pops, then one cycle of word_valid = 1, word_data = 0x39, word_count = 4.
REQ-032 Push 1,2,3,0,3,2,1,0 with word_ready held 0 until the first word appears -> first word 0x39 is held stable, pops stop, FIFO full = 1. Then raise word_ready -> second word 0x1B follows with no lost or duplicated symbol.
REQ-033 Push 3,1, then pulse flush for one cycle -> word_data = 0x07, word_count = 2, word_valid = 1 until accepted.
REQ-034 Flush pulse with FIFO empty and idx = 0 -> word_valid stays 0 and fifo_pop stays 0.
REQ-035 Continuous stream of 12 symbols with word_ready = 1 -> 3 words, no idle cycle between a handoff and the next pop.
REQ-036 Assert reset after 2 symbols, release, then push 2,2,2,2 -> only word 0xAA appears, word_count = 4.
